alu_bist_driver: RTL and testbench

//  Built-in self-test initiator for the single-cycle ALU. Walks a fixed vector

---
 rtl/mips_pkg.sv | 20 ++
 rtl/alu_bist_driver_if.sv | 23 ++
 rtl/alu_vec_rom.sv | 37 +++
 rtl/alu_bist_driver.sv | 124 ++++++++++++
 tb/tb_alu_bist_driver.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared ALU definitions: ALU control codes and the BIST driver FSM state encoding.
// No logic of its own; the codes match the datapath ALU control decoder.
// Any module that drives or decodes ALU ops imports this package.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_bist_driver_if.sv
// ALU operand/result bus between the BIST driver (master) and the ALU (slave).
// Pure wiring, no latency.
// No flow control: the ALU is combinational and always ready.
interface alu_bist_driver_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_c;
    logic              alu_zero;

    modport master (
        output alu_a, alu_b, alu_op,
        input  alu_c, alu_zero
    );

    modport slave (
        input  alu_a, alu_b, alu_op,
        output alu_c, alu_zero
    );
endinterface

// File: rtl/alu_vec_rom.sv
// Fixed ALU self-test vector table: operands, op code and expected result per index.
// Combinational, zero latency.
// No backpressure; out-of-range indices return an all-zero AND vector.
module alu_vec_rom
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int IDX_W  = 4
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] exp_c
);

    // Table lookup; expected results are modulo 2^DATA_W.
    always_comb begin
        a     = '0;
        b     = '0;
        op    = OP_W'(ALU_AND);
        exp_c = '0;
        case (idx)
            IDX_W'(0): begin a = DATA_W'(12); b = DATA_W'(15); op = OP_W'(ALU_AND); exp_c = DATA_W'(12); end
            IDX_W'(1): begin a = DATA_W'(17); b = DATA_W'(20); op = OP_W'(ALU_OR);  exp_c = DATA_W'(21); end
            IDX_W'(2): begin a = DATA_W'(5);  b = DATA_W'(7);  op = OP_W'(ALU_ADD); exp_c = DATA_W'(12); end
            IDX_W'(3): begin a = DATA_W'(9);  b = DATA_W'(9);  op = OP_W'(ALU_SUB); exp_c = '0;          end
            IDX_W'(4): begin a = DATA_W'(3);  b = DATA_W'(8);  op = OP_W'(ALU_SLT); exp_c = DATA_W'(1);  end
            IDX_W'(5): begin a = '0;          b = '0;          op = OP_W'(ALU_NOR); exp_c = '1;          end
            IDX_W'(6): begin a = '1;          b = DATA_W'(1);  op = OP_W'(ALU_ADD); exp_c = '0;          end
            IDX_W'(7): begin a = '0;          b = DATA_W'(1);  op = OP_W'(ALU_SUB); exp_c = '1;          end
            default:   ;
        endcase
    end

endmodule

// File: rtl/alu_bist_driver.sv
// ALU built-in self-test initiator: drives each table vector, checks C/zero, reports pass/fail.
// Two cycles per vector (DRIVE then CHECK); done rises 2*NUM_VEC+1 edges after start is sampled.
// start is ignored while busy; results hold in DONE until the next start.
module alu_bist_driver
    import mips_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  OP_W    = 4,
    parameter int  NUM_VEC = 8,
    localparam int IDX_W   = $clog2(NUM_VEC + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    alu_bist_driver_if.master   alu,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [IDX_W-1:0]    fail_count,
    output logic [IDX_W-1:0]    first_fail
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               load;
    logic               check;
    logic               mismatch;
    logic [DATA_W-1:0]  exp_c;

    logic [DATA_W-1:0]  rom_a, rom_b, rom_exp;
    logic [OP_W-1:0]    rom_op;

    // The ROM is addressed by the index being entered so the vector can be
    // registered on the same edge that enters DRIVE.
    alu_vec_rom #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .IDX_W  (IDX_W)
    ) u_rom (
        .idx    (idx_nxt),
        .a      (rom_a),
        .b      (rom_b),
        .op     (rom_op),
        .exp_c  (rom_exp)
    );

    assign busy     = (state == DRIVE) || (state == CHECK);
    assign done     = (state == DONE);
    assign pass     = done && (fail_count == '0);
    assign mismatch = (alu.alu_c != exp_c) || (alu.alu_zero != (exp_c == '0));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, vector index advance and load/check strobes.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        check     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    idx_nxt   = '0;
                    load      = 1'b1;
                end
            end
            DRIVE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                check = 1'b1;
                if (idx < IDX_W'(NUM_VEC - 1)) begin
                    state_nxt = DRIVE;
                    idx_nxt   = idx + IDX_W'(1);
                    load      = 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers and result accounting; a new run clears the counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            alu.alu_a  <= '0;
            alu.alu_b  <= '0;
            alu.alu_op <= '0;
            exp_c      <= '0;
            fail_count <= '0;
            first_fail <= '0;
        end else begin
            if (load) begin
                idx        <= idx_nxt;
                alu.alu_a  <= rom_a;
                alu.alu_b  <= rom_b;
                alu.alu_op <= rom_op;
                exp_c      <= rom_exp;
            end
            if (start && !busy) begin
                fail_count <= '0;
                first_fail <= '0;
            end else if (check && mismatch) begin
                if (fail_count != IDX_W'(NUM_VEC)) begin
                    fail_count <= fail_count + IDX_W'(1);
                end
                if (fail_count == '0) begin
                    first_fail <= idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_bist_driver.sv
// Self-checking bench for alu_bist_driver with a behavioural ALU that can be faulted.
// Table-driven full runs plus hand sequences for restart, abort and re-start.
// Every wait on the DUT is bounded by a cycle budget.
module tb_alu_bist_driver;
    import mips_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_count;
    logic [3:0] first_fail;

    int n_cmp  = 0;
    int n_fail = 0;
    int fault  = 0;

    alu_bist_driver_if #(.DATA_W(32), .OP_W(4)) bus ();

    alu_bist_driver #(.DATA_W(32), .OP_W(4), .NUM_VEC(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .alu        (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count),
        .first_fail (first_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU: 0 good, 1 OR acts as AND, 2 zero stuck 0, 3 C stuck 0, 4 C off by one.
    logic [31:0] good_c, c_val;
    always_comb begin
        good_c = '0;
        case (bus.alu_op)
            ALU_AND: good_c = bus.alu_a & bus.alu_b;
            ALU_OR:  good_c = bus.alu_a | bus.alu_b;
            ALU_ADD: good_c = bus.alu_a + bus.alu_b;
            ALU_SUB: good_c = bus.alu_a - bus.alu_b;
            ALU_SLT: good_c = {31'b0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            ALU_NOR: good_c = ~(bus.alu_a | bus.alu_b);
            default: good_c = '0;
        endcase
        c_val = good_c;
        if (fault == 1 && bus.alu_op == ALU_OR) c_val = bus.alu_a & bus.alu_b;
        if (fault == 3) c_val = '0;
        if (fault == 4) c_val = good_c + 32'd1;
        bus.alu_c    = c_val;
        bus.alu_zero = (fault == 2) ? 1'b0 : (c_val == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge, optionally re-pulse after edge restart_at, wait for done.
    task automatic run(input int restart_at, output int edges, output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        edges = 0;
        busy_cycles = 0;
        while (edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = (edges == restart_at);
            if (busy) busy_cycles++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int   fault;
        int   exp_fc;
        int   exp_ff;
        logic exp_pass;
    } vec_t;

    vec_t tbl[5];
    int   edges, bc;

    initial begin
        tbl[0] = '{0, 0, 0, 1'b1};
        tbl[1] = '{1, 1, 1, 1'b0};
        tbl[2] = '{2, 2, 3, 1'b0};
        tbl[3] = '{3, 6, 0, 1'b0};
        tbl[4] = '{4, 8, 0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        #12;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset pass", 32'(pass), 0);
        check("reset fail_count", 32'(fail_count), 0);
        check("reset first_fail", 32'(first_fail), 0);
        check("reset alu_a", bus.alu_a, 0);
        check("reset alu_op", 32'(bus.alu_op), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            fault = tbl[i].fault;
            run(-1, edges, bc);
            check($sformatf("v%0d done edge", i), edges, 17);
            check($sformatf("v%0d busy cycles", i), bc, 16);
            check($sformatf("v%0d busy low", i), 32'(busy), 0);
            check($sformatf("v%0d pass", i), 32'(pass), 32'(tbl[i].exp_pass));
            check($sformatf("v%0d fail_count", i), 32'(fail_count), tbl[i].exp_fc);
            if (tbl[i].exp_fc != 0)
                check($sformatf("v%0d first_fail", i), 32'(first_fail), tbl[i].exp_ff);
        end

        // Operands hold the last vector (SUB 0,1) in DONE.
        check("done hold alu_op", 32'(bus.alu_op), 32'(ALU_SUB));
        check("done hold alu_b", bus.alu_b, 1);

        // Start from DONE clears counts and loads vector 0 on the next edge.
        fault = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart done", 32'(done), 0);
        check("restart busy", 32'(busy), 1);
        check("restart fail_count", 32'(fail_count), 0);
        check("restart alu_op", 32'(bus.alu_op), 32'(ALU_AND));
        check("restart alu_a", bus.alu_a, 12);
        check("restart alu_b", bus.alu_b, 15);
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        check("restart run pass", 32'(pass), 1);

        // Start during vector 4 CHECK is ignored.
        fault = 2;
        run(10, edges, bc);
        check("ignored start done edge", edges, 17);
        check("ignored start fail_count", 32'(fail_count), 2);
        check("ignored start first_fail", 32'(first_fail), 3);

        // Asynchronous reset mid-run, after vector 1 has already failed.
        fault = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort fail_count", 32'(fail_count), 0);
        check("abort first_fail", 32'(first_fail), 0);
        check("abort alu_a", bus.alu_a, 0);
        check("abort alu_b", bus.alu_b, 0);
        check("abort alu_op", 32'(bus.alu_op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        run(-1, edges, bc);
        check("post abort done edge", edges, 17);
        check("post abort pass", 32'(pass), 1);
        check("post abort fail_count", 32'(fail_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
